// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: next-PC select codes,
// opcode constants and the fetch state encoding.
package cpu_pkg;

  localparam logic [1:0] PCSRC_NEXT   = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_REG    = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  // Absolute jump target: top nibble of the sequential PC, 26-bit index, word aligned.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] jump_idx);
    return {pc_plus4[31:28], jump_idx, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch,
// register indirect (jr) and absolute jump.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs_data,
  input  logic [25:0] jump_idx,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  assign pc_plus4 = pc + 32'd4;

  // Select the next PC; all sums wrap modulo 2^32.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PCSRC_NEXT:   next_pc = pc_plus4;
      PCSRC_BRANCH: next_pc = pc_plus4 + {imm_ext[29:0], 2'b00};
      PCSRC_REG:    next_pc = rs_data;
      PCSRC_JUMP:   next_pc = jump_target(pc_plus4, jump_idx);
      default:      next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/PC stage: program counter, instruction register and a
// request/acknowledge fetch from instruction memory.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FETCH_IDLE | no fetch outstanding; IRWre starts a fetch, PCWre updates pc
// FETCH_WAIT | imem_req held; PCWre parks the target in pending_pc until ack
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   PCWre,
  input  logic                   IRWre,
  input  logic [1:0]             PCSrc,
  input  logic [31:0]            imm_ext,
  input  logic [31:0]            rs_data,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic [31:0]            ir,
  output logic [5:0]             opcode,
  output logic                   ir_valid,
  output logic                   busy
);

  fetch_state_e state, state_next;
  logic         fetch_start;
  logic         fetch_done;
  logic         pending;
  logic [31:0]  pending_pc;
  logic [31:0]  next_pc;

  next_pc_calc u_next_pc_calc (
    .pc       (pc),
    .pc_src   (PCSrc),
    .imm_ext  (imm_ext),
    .rs_data  (rs_data),
    .jump_idx (ir[25:0]),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  // Fetch state register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state <= FETCH_IDLE;
    else      state <= state_next;
  end

  // Next state plus start/finish strobes; IRWre during WAIT is deliberately ignored.
  always_comb begin
    state_next  = state;
    fetch_start = 1'b0;
    fetch_done  = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (IRWre) begin
          fetch_start = 1'b1;
          state_next  = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_ack) begin
          fetch_done = 1'b1;
          state_next = FETCH_IDLE;
        end
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  // Memory request, address and instruction register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      imem_req  <= 1'b0;
      imem_addr <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
    end else begin
      if (fetch_start) begin
        imem_addr <= pc[IMEM_ADDR_W-1:0];
        imem_req  <= 1'b1;
        ir_valid  <= 1'b0;
      end
      if (fetch_done) begin
        ir       <= imem_rdata;
        ir_valid <= 1'b1;
        imem_req <= 1'b0;
      end
    end
  end

  // Parks a PC update requested mid-fetch; the newest request wins.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      pending    <= 1'b0;
      pending_pc <= '0;
    end else if (state == FETCH_WAIT) begin
      if (imem_ack) begin
        pending <= 1'b0;
      end else if (PCWre) begin
        pending    <= 1'b1;
        pending_pc <= next_pc;
      end
    end
  end

  // Program counter: direct update in IDLE, deferred update on the accepting ack.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      pc <= RESET_PC;
    end else if (state == FETCH_IDLE) begin
      if (PCWre) pc <= next_pc;
    end else if (imem_ack) begin
      if (PCWre)        pc <= next_pc;
      else if (pending) pc <= pending_pc;
    end
  end

  assign opcode = ir[31:26];
  assign busy   = (state == FETCH_WAIT) | pending;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random
// control-unit/memory stimulus, all checked against a transaction model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        RST;
  logic        PCWre, IRWre;
  logic [1:0]  PCSrc;
  logic [31:0] imm_ext, rs_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc, pc_plus4, ir;
  logic [5:0]  opcode;
  logic        ir_valid, busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_ir, m_addr, m_pend_pc;
  logic        m_irv, m_req, m_fetching, m_pend;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .IMEM_ADDR_W (32)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .PCWre      (PCWre),
    .IRWre      (IRWre),
    .PCSrc      (PCSrc),
    .imm_ext    (imm_ext),
    .rs_data    (rs_data),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .ir         (ir),
    .opcode     (opcode),
    .ir_valid   (ir_valid),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] spec_next_pc(input logic [1:0] src, input logic [31:0] p,
                                               input logic [31:0] instr, input logic [31:0] imm,
                                               input logic [31:0] rs);
    logic [31:0] seq;
    seq = p + 32'd4;
    case (src)
      2'b00:   return seq;
      2'b01:   return seq + imm * 32'd4;
      2'b10:   return rs;
      default: return {seq[31:28], instr[25:0], 2'b00};
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 32'h0; m_addr = 32'h0; m_pend_pc = 32'h0;
    m_irv = 1'b0; m_req = 1'b0; m_fetching = 1'b0; m_pend = 1'b0;
  endtask

  // One clock edge of the stage as seen by the control unit and memory.
  task automatic model_edge(input logic pw, input logic iw, input logic [1:0] src,
                            input logic [31:0] imm, input logic [31:0] rs,
                            input logic ack, input logic [31:0] rd);
    logic [31:0] target;
    target = spec_next_pc(src, m_pc, m_ir, imm, rs);
    if (!m_fetching) begin
      if (iw) begin
        m_addr = m_pc;
        m_req = 1'b1;
        m_irv = 1'b0;
        m_fetching = 1'b1;
      end
      if (pw) m_pc = target;
    end else begin
      if (pw) begin
        m_pend = 1'b1;
        m_pend_pc = target;
      end
      if (ack) begin
        m_ir = rd;
        m_irv = 1'b1;
        m_req = 1'b0;
        m_fetching = 1'b0;
        if (m_pend) begin
          m_pc = m_pend_pc;
          m_pend = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all(input string where);
    check_val({where, "_pc"},       pc,                  m_pc);
    check_val({where, "_pc_plus4"}, pc_plus4,            m_pc + 32'd4);
    check_val({where, "_ir"},       ir,                  m_ir);
    check_val({where, "_opcode"},   {26'd0, opcode},     {26'd0, m_ir[31:26]});
    check_val({where, "_ir_valid"}, {31'd0, ir_valid},   {31'd0, m_irv});
    check_val({where, "_imem_req"}, {31'd0, imem_req},   {31'd0, m_req});
    check_val({where, "_imem_addr"}, imem_addr,          m_addr);
    check_val({where, "_busy"},     {31'd0, busy},       {31'd0, m_fetching | m_pend});
  endtask

  // Called at a falling edge: drive, advance the model, compare at the next falling edge.
  task automatic step(input logic pw, input logic iw, input logic [1:0] src,
                      input logic [31:0] imm, input logic [31:0] rs,
                      input logic ack, input logic [31:0] rd, input string tag);
    PCWre = pw; IRWre = iw; PCSrc = src; imm_ext = imm; rs_data = rs;
    imem_ack = ack; imem_rdata = rd;
    model_edge(pw, iw, src, imm, rs, ack, rd);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic set_pc(input logic [31:0] v);
    step(1'b1, 1'b0, 2'b10, 32'h0, v, 1'b0, 32'h0, "set_pc");
  endtask

  task automatic apply_reset();
    RST = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    @(negedge clk);
    compare_all("rst_hold");
    RST = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    RST = 1'b0; PCWre = 1'b0; IRWre = 1'b0; PCSrc = 2'b00;
    imm_ext = 32'h0; rs_data = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    RST = 1'b1;

    // Fetch from reset, memory answers on the third wait cycle
    step(1'b0, 1'b1, 2'b00, 0, 0, 1'b0, 0, "tp1_start");
    check_val("tp1_addr", imem_addr, 32'h0);
    check_val("tp1_req", {31'd0, imem_req}, 32'd1);
    step(1'b0, 1'b0, 2'b00, 0, 0, 1'b0, 0, "tp1_wait");
    step(1'b0, 1'b0, 2'b00, 0, 0, 1'b0, 0, "tp1_wait");
    step(1'b0, 1'b0, 2'b00, 0, 0, 1'b1, 32'h0022_1800, "tp1_ack");
    check_val("tp1_ir", ir, 32'h0022_1800);
    check_val("tp1_opcode", {26'd0, opcode}, 32'd0);
    check_val("tp1_ir_valid", {31'd0, ir_valid}, 32'd1);
    check_val("tp1_busy", {31'd0, busy}, 32'd0);

    // PC update and fetch on the same edge
    set_pc(32'h10);
    step(1'b1, 1'b1, 2'b00, 0, 0, 1'b0, 0, "tp2_both");
    check_val("tp2_addr", imem_addr, 32'h10);
    check_val("tp2_pc", pc, 32'h14);
    step(1'b0, 1'b0, 2'b00, 0, 0, 1'b1, 32'h1234_5678, "tp2_ack");

    // Branch backwards and register jump
    set_pc(32'h20);
    step(1'b1, 1'b0, 2'b01, 32'hFFFF_FFFE, 0, 1'b0, 0, "tp3_branch");
    check_val("tp3_branch_pc", pc, 32'h1C);
    step(1'b1, 1'b0, 2'b10, 0, 32'h40, 1'b0, 0, "tp3_jr");
    check_val("tp3_jr_pc", pc, 32'h40);

    // Absolute jump keeps the top nibble; sequential wrap at the top of memory
    set_pc(32'hF000_0000);
    step(1'b0, 1'b1, 2'b00, 0, 0, 1'b0, 0, "tp4_fetch");
    step(1'b0, 1'b0, 2'b00, 0, 0, 1'b1, 32'h0800_0010, "tp4_ack");
    step(1'b1, 1'b0, 2'b11, 0, 0, 1'b0, 0, "tp4_jump");
    check_val("tp4_jump_pc", pc, 32'hF000_0040);
    set_pc(32'hFFFF_FFFC);
    step(1'b1, 1'b0, 2'b00, 0, 0, 1'b0, 0, "tp4_wrap");
    check_val("tp4_wrap_pc", pc, 32'h0);

    // Deferred PC update during a fetch; extra IRWre while waiting
    set_pc(32'h8);
    step(1'b0, 1'b1, 2'b00, 0, 0, 1'b0, 0, "tp5_fetch");
    step(1'b1, 1'b0, 2'b00, 0, 0, 1'b0, 0, "tp5_pcwre");
    check_val("tp5_pc_held", pc, 32'h8);
    check_val("tp5_busy", {31'd0, busy}, 32'd1);
    step(1'b0, 1'b1, 2'b00, 0, 0, 1'b0, 0, "tp5_irwre");
    check_val("tp5_pc_held2", pc, 32'h8);
    step(1'b0, 1'b0, 2'b00, 0, 0, 1'b1, 32'hAC22_0004, "tp5_ack");
    check_val("tp5_pc_applied", pc, 32'hC);
    check_val("tp5_busy_low", {31'd0, busy}, 32'd0);
    step(1'b0, 1'b0, 2'b00, 0, 0, 1'b0, 0, "tp5_idle");
    check_val("tp5_no_rereq", {31'd0, imem_req}, 32'd0);

    // Reset mid-fetch, then a stale ack after release
    step(1'b0, 1'b1, 2'b00, 0, 0, 1'b0, 0, "tp6_fetch");
    apply_reset();
    check_val("tp6_req_dropped", {31'd0, imem_req}, 32'd0);
    step(1'b0, 1'b0, 2'b00, 0, 0, 1'b1, 32'hDEAD_BEEF, "tp6_late_ack");
    check_val("tp6_ir", ir, 32'h0);
    check_val("tp6_ir_valid", {31'd0, ir_valid}, 32'd0);

    // Random control-unit and memory behaviour
    for (int i = 0; i < 600; i++) begin
      logic pw, iw, ack;
      logic [1:0] src;
      logic [31:0] imm;
      if (i % 200 == 199) apply_reset();
      pw  = ($urandom % 4) == 0;
      iw  = ($urandom % 3) == 0;
      src = 2'($urandom % 4);
      r   = $urandom;
      imm = {{16{r[15]}}, r[15:0]};
      ack = m_fetching ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
      step(pw, iw, src, imm, $urandom, ack, $urandom, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch and PC stage of the multicycle CPU, directly upstream of the control unit. It holds the program counter and the instruction register and computes the next PC from the control unit's `PCSrc`. It runs a request/acknowledge fetch from instruction memory and presents `opcode` back to the control unit. It applies `PCWre`/`IRWre` strobes and stalls (`busy`) while a fetch is outstanding.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `IMEM_ADDR_W`, 32, width of `imem_addr`

Ports:
- `clk`  in  1  rising-edge clock
- `RST`  in  1  asynchronous, active-low reset
- `PCWre`  in  1  PC update strobe from control unit
- `IRWre`  in  1  instruction fetch/load strobe from control unit
- `PCSrc`  in  2  next-PC select: 00 PC+4, 01 branch, 10 register (jr), 11 jump
- `imm_ext`  in  32  sign-extended 16-bit immediate of current instruction
- `rs_data`  in  32  register-file rs read value (jr target)
- `imem_req`  out  1  fetch request, held until `imem_ack`
- `imem_addr`  out  IMEM_ADDR_W  fetch address, stable while `imem_req`
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle
- `imem_rdata`  in  32  instruction word
- `pc`  out  32  current PC
- `pc_plus4`  out  32  pc + 4 (jal link value)
- `ir`  out  32  instruction register
- `opcode`  out  6  `ir[31:26]`
- `ir_valid`  out  1  `ir` holds a fetched word
- `busy`  out  1  fetch outstanding; control unit must hold its state

## Operation
- Reset (RST=0, async): `pc`=RESET_PC, `ir`=0, `ir_valid`=0, `imem_req`=0, `imem_addr`=0, `busy`=0, pending=0, state IDLE.
- Next PC, computed combinationally:
  - 00 → pc+4
  - 01 → pc+4+(imm_ext<<2)
  - 10 → rs_data
  - 11 → {pc_plus4[31:28], ir[25:0], 2'b00}
  - All arithmetic is mod 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- FSM states IDLE, WAIT:
  - IDLE, IRWre=1: `imem_addr`←pc, `imem_req`←1, `ir_valid`←0, go WAIT.
  - WAIT: `imem_req` stays 1. On `imem_ack`: `ir`←imem_rdata, `ir_valid`←1, `imem_req`←0, go IDLE.
  - IRWre while in WAIT: ignored; no second request.
- PC update:
  - IDLE, PCWre=1: pc←next_pc at the same edge.
  - Simultaneous PCWre and IRWre in IDLE: the fetch uses the old pc (address captured from the current pc); pc advances at the same edge.
  - PCWre in WAIT: the next_pc value is captured into a pending register with pending←1. It is applied to pc on the edge the ack is accepted, then pending←0.
  - A second PCWre while pending=1 overwrites the pending value; last wins.
- `busy` = (state==WAIT) | pending.
- RST asserted mid-fetch: request dropped immediately. An `imem_ack` arriving after reset release while in IDLE is ignored.

## Timing
- `imem_req` rises one cycle after the IRWre edge.
- Minimum fetch latency: ack in the first WAIT cycle gives `ir` valid 2 cycles after the IRWre edge.
- `imem_addr` and `imem_req` are registered; no combinational path from `imem_ack` to `imem_req`.
- `opcode`, `pc_plus4`, `busy` are combinational from registers only.
- Branch target uses pc at the cycle PCWre is sampled. The control unit guarantees `imm_ext`, `rs_data` and `PCSrc` are stable that cycle.

## Structure
- Shared package `cpu_pkg`:
  - PCSrc encodings PCSRC_NEXT/BRANCH/REG/JUMP
  - opcode constants (add, lw, sw, beq, j, jr, jal, halt …)
  - fetch state enum
- Sub-module `next_pc_calc`: combinational mux/adders producing next_pc and pc_plus4.
- FSM, PC, pending and IR registers stay in the top module.

## Test plan
- Reset then IRWre pulse, memory acks after 3 cycles with 32'h0022_1800 → `imem_addr`=0, `ir`=32'h0022_1800, `opcode`=6'b000000, `ir_valid`=1, `busy` low after ack.
- PCWre+IRWre together, PCSrc=00, pc=0x10 → fetch address 0x10, pc=0x14 next cycle.
- PCSrc=01, pc=0x20, imm_ext=32'hFFFF_FFFE → pc=0x1C. PCSrc=10, rs_data=0x40 → pc=0x40.
- PCSrc=11, pc=0xF000_0000, ir[25:0]=26'h10 → pc=0xF000_0040. pc=0xFFFF_FFFC with PCSrc=00 → pc=0.
- PCWre during WAIT with PCSrc=00, pc=0x8 → pc stays 0x8 and `busy`=1 until ack, then pc=0xC. A second IRWre in WAIT gives no extra request.
- RST low while `imem_req`=1, late ack after release → all outputs at reset values, `ir` unchanged (0), `ir_valid`=0.
